// File: rtl/vga_display_driver.sv
// VGA output stage: derives the pixel-rate enable from clk, runs the
// horizontal/vertical raster counters, publishes the current coordinate,
// and registers blanked colour plus active-low syncs onto the pins. Sync
// is registered on the same enable as colour, so both lag the published
// coordinate by exactly one pixel period.
module vga_display_driver #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] pixel_data,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        pix_ce,
    output logic        frame_start,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             hs_next;
    logic             vs_next;
    logic [11:0]      rgb_next;

    assign pix_ce      = (div_cnt == DIV_LAST);
    assign h_wrap      = (h_cnt == H_LAST);
    assign v_wrap      = (v_cnt == V_LAST);
    assign frame_start = pix_ce & h_wrap & v_wrap;
    assign video_on    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;

    // Sync and colour values for the coordinate currently on pixel_x/pixel_y.
    always_comb begin
        hs_next  = ~((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_next  = ~((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        rgb_next = video_on ? pixel_data : 12'h000;
    end

    // Pixel-enable divider: counts 0..CLK_DIV-1, pix_ce marks the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (pix_ce) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Raster counters: h steps every pixel, v steps on each h wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Pin register: colour and syncs captured together once per pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r  <= 4'h0;
            vga_g  <= 4'h0;
            vga_b  <= 4'h0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else if (pix_ce) begin
            vga_r  <= rgb_next[11:8];
            vga_g  <= rgb_next[7:4];
            vga_b  <= rgb_next[3:0];
            vga_hs <= hs_next;
            vga_vs <= vs_next;
        end
    end

endmodule

// File: tb/tb_vga_display_driver.sv
// Bench for vga_display_driver using a shrunken raster so several frames
// fit in a short run. A cycle-count model predicts coordinates and strobes;
// pin values are pushed to a scoreboard on each predicted pixel enable and
// popped at the following edge.
module tb_vga_display_driver;

    localparam int D  = 4;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int LINE  = HT * D;
    localparam int FRAME = HT * VT * D;
    localparam logic [13:0] RST_PINS = 14'b0000_0000_0000_11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] pixel_data;
    logic [11:0] pd_reg;
    logic        loop_mode;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, pix_ce, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    logic [13:0] exp_pins;
    logic [13:0] sb[$];

    int hs_run, vs_run, last_fs, fs_cnt;
    bit prev_hs, prev_vs, first_ce_done;

    always #5 clk = ~clk;

    assign pixel_data = loop_mode ? {2'b00, pixel_x} : pd_reg;

    vga_display_driver #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .pix_ce(pix_ce), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_meas();
        hs_run = 0; vs_run = 0; last_fs = -1; fs_cnt = 0;
        prev_hs = 1'b1; prev_vs = 1'b1; first_ce_done = 1'b0;
    endtask

    task automatic check_now();
        int div, p, h, v;
        bit ce;
        logic [11:0] pd, rgb;
        logic hs, vs;
        div = cyc % D;
        p   = cyc / D;
        h   = p % HT;
        v   = (p / HT) % VT;
        ce  = (div == D - 1);
        chk("pixel_x", pixel_x, h);
        chk("pixel_y", pixel_y, v);
        chk("video_on", video_on, (h < HA) && (v < VA));
        chk("pix_ce", pix_ce, ce);
        chk("frame_start", frame_start, ce && (h == HT - 1) && (v == VT - 1));
        chk("pins", {vga_r, vga_g, vga_b, vga_hs, vga_vs}, exp_pins);
        if (ce) begin
            pd  = loop_mode ? {2'b00, 10'(h)} : pd_reg;
            rgb = ((h < HA) && (v < VA)) ? pd : 12'h000;
            hs  = !((h >= HA + HF) && (h < HA + HF + HS));
            vs  = !((v >= VA + VF) && (v < VA + VF + VS));
            sb.push_back({rgb, hs, vs});
        end
        if (pix_ce && !first_ce_done && rst_n) begin
            chk("first_ce_edge", cyc + 1, D);
            first_ce_done = 1'b1;
        end
        if (!vga_hs) hs_run++;
        else if (hs_run > 0) begin
            chk("hs_low_clks", hs_run, HS * D);
            hs_run = 0;
        end
        if (!vga_vs) vs_run++;
        else if (vs_run > 0) begin
            chk("vs_low_clks", vs_run, VS * LINE);
            vs_run = 0;
        end
        if (prev_hs && !vga_hs) chk("hs_fall_x", pixel_x, HA + HF + 1);
        if (prev_vs && !vga_vs) chk("vs_fall_xy", {pixel_y, pixel_x}, {10'(VA + VF), 10'd1});
        prev_hs = vga_hs;
        prev_vs = vga_vs;
        if (frame_start) begin
            if (last_fs < 0) chk("fs_first", cyc, FRAME - 1);
            else chk("fs_period", cyc - last_fs, FRAME);
            last_fs = cyc;
            fs_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) cyc++;
        if (sb.size() > 0) exp_pins = sb.pop_front();
        @(negedge clk);
        check_now();
    endtask

    task automatic align();
        for (int i = 0; i < D && (cyc % D) != 0; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; pd_reg = 12'hFFF; loop_mode = 1'b0;
        cyc = 0; exp_pins = RST_PINS;
        reset_meas();
        @(negedge clk);
        repeat (10) tick();
        rst_n = 1'b1;
        repeat (2 * LINE) tick();

        align();
        pd_reg = 12'hA5C;
        repeat (2 * FRAME + LINE) tick();

        align();
        loop_mode = 1'b1;
        repeat (FRAME) tick();

        for (int i = 0; i < FRAME && (cyc % FRAME) != (5 * HT + 10) * D; i++) tick();
        chk("mrst_pos", {pixel_y, pixel_x}, {10'd5, 10'd10});
        rst_n = 1'b0;
        #1;
        chk("mrst_x", pixel_x, 0);
        chk("mrst_y", pixel_y, 0);
        chk("mrst_ce", pix_ce, 0);
        chk("mrst_fs", frame_start, 0);
        chk("mrst_von", video_on, 1);
        chk("mrst_pins", {vga_r, vga_g, vga_b, vga_hs, vga_vs}, RST_PINS);
        cyc = 0;
        sb.delete();
        exp_pins = RST_PINS;
        reset_meas();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2 * FRAME + 10) tick();
        chk("fs_count", fs_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
